// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I core types and constants.
package rv32i_pkg;
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t RESET_ENTRY = '{pc: '0, instr: NOP_INSTR};
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO of fetched {pc, instr} pairs with flush and async reset.
module fetch_buf
    import rv32i_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);
    fetch_entry_t mem_q [2];
    logic         head_q;
    logic         tail_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= RESET_ENTRY;
            mem_q[1] <= RESET_ENTRY;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= data_i;
                tail_q        <= ~tail_q;
            end
            if (pop_i) head_q <= ~head_q;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage - PC register, ROM addressing, 2-entry fetch buffer, redirect flush.
// Define INSTR_FETCH_BOUNDS_CHECK_EN to enable alignment/range fault detection.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS = 101
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault
);
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         pop;
    logic         push;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t wr_entry;

    assign pop  = id_valid && id_ready;
    assign push = !redirect_valid && (count < 2'd2 || pop);
    assign pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc_q + 32'd4 : pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

`ifdef INSTR_FETCH_BOUNDS_CHECK_EN
    logic oob;
    logic fault_q;
    assign oob      = pc_q[31:2] >= 30'(IMEM_WORDS);
    assign wr_entry = '{pc: pc_q, instr: oob ? NOP_INSTR : imem_instr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_q | (redirect_valid && |redirect_pc[1:0]) | (push && oob);
    end

    assign fetch_fault = fault_q;
`else
    localparam int unsigned unused_words = IMEM_WORDS;
    logic [1:0] unused_lsb;
    assign unused_lsb  = redirect_pc[1:0];
    assign wr_entry    = '{pc: pc_q, instr: imem_instr};
    assign fetch_fault = 1'b0;
`endif

    fetch_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  (wr_entry),
        .head_o  (head),
        .count_o (count)
    );

    assign imem_addr   = pc_q;
    assign id_valid    = count != 2'd0;
    assign id_instr    = head.instr;
    assign id_pc       = head.pc;
    assign id_pc_plus4 = head.pc + 32'd4;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b1;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_fault;
    int          n_checks = 0;
    int          n_fail = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INSTR_FETCH_BOUNDS_CHECK_EN
    localparam logic BOUNDS = 1'b1;
`else
    localparam logic BOUNDS = 1'b0;
`endif

    always #5 clk = ~clk;

    // ROM word n holds 32'hA000_0000 | n, so each word is unique and easy to predict
    assign imem_instr = 32'hA000_0000 | {2'b00, imem_addr[31:2]};

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_fault    (fetch_fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string name, input logic [31:0] pc, input logic [31:0] instr);
        n_checks++;
        if (id_valid !== 1'b1) begin n_fail++; $display("FAIL %s id_valid: got %b expected 1", name, id_valid); end
        n_checks++;
        if (id_pc !== pc) begin n_fail++; $display("FAIL %s id_pc: got %h expected %h", name, id_pc, pc); end
        n_checks++;
        if (id_instr !== instr) begin n_fail++; $display("FAIL %s id_instr: got %h expected %h", name, id_instr, instr); end
        n_checks++;
        if (id_pc_plus4 !== pc + 32'd4) begin n_fail++; $display("FAIL %s id_pc_plus4: got %h expected %h", name, id_pc_plus4, pc + 32'd4); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset id_valid: got %b expected 0", id_valid); end
        n_checks++;
        if (id_instr !== NOP) begin n_fail++; $display("FAIL reset id_instr: got %h expected %h", id_instr, NOP); end
        n_checks++;
        if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset id_pc: got %h expected 0", id_pc); end
        n_checks++;
        if (id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset id_pc_plus4: got %h expected 4", id_pc_plus4); end
        n_checks++;
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset imem_addr: got %h expected 0", imem_addr); end
        n_checks++;
        if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset fetch_fault: got %b expected 0", fetch_fault); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        id_ready = 1'b1;
        expect_head_loop: for (int k = 0; k < 4; k++) begin
            step();
            expect_head("stream", 32'(4 * k), 32'hA000_0000 | 32'(k));
        end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            expect_head("stall", 32'd12, 32'hA000_0003);
            n_checks++;
            if (imem_addr !== 32'd20) begin n_fail++; $display("FAIL stall imem_addr: got %h expected %h", imem_addr, 32'd20); end
        end
        id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            expect_head("drain", 32'(16 + 4 * k), 32'hA000_0000 | 32'(4 + k));
        end
    endtask

    task automatic test_redirect();
        id_ready = 1'b0;
        step();
        expect_head("redir_pre", 32'd28, 32'hA000_0007);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        n_checks++;
        if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush id_valid: got %b expected 0", id_valid); end
        n_checks++;
        if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir imem_addr: got %h expected 40", imem_addr); end
        step();
        expect_head("redir_tgt", 32'h40, 32'hA000_0010);
        step();
        expect_head("redir_next", 32'h44, 32'hA000_0011);
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        step();
        n_checks++;
        if (id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_first id_valid: got %b expected 0", id_valid); end
        redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (id_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_second id_valid: got %b expected 0", id_valid); end
        n_checks++;
        if (imem_addr !== 32'h80) begin n_fail++; $display("FAIL b2b imem_addr: got %h expected 80", imem_addr); end
        step();
        expect_head("b2b_tgt", 32'h80, 32'hA000_0020);
        step();
        expect_head("b2b_next", 32'h84, 32'hA000_0021);
    endtask

    task automatic test_bounds();
        redirect_valid = 1'b1;
        redirect_pc = 32'h62;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_addr !== 32'h60) begin n_fail++; $display("FAIL misalign imem_addr: got %h expected 60", imem_addr); end
        n_checks++;
        if (fetch_fault !== BOUNDS) begin n_fail++; $display("FAIL misalign fetch_fault: got %b expected %b", fetch_fault, BOUNDS); end
        step();
        expect_head("misalign_tgt", 32'h60, 32'hA000_0018);
        n_checks++;
        if (fetch_fault !== BOUNDS) begin n_fail++; $display("FAIL sticky fetch_fault: got %b expected %b", fetch_fault, BOUNDS); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h194;
        step();
        redirect_valid = 1'b0;
        step();
        expect_head("oob_tgt", 32'h194, BOUNDS ? NOP : 32'hA000_0065);
        n_checks++;
        if (fetch_fault !== BOUNDS) begin n_fail++; $display("FAIL oob fetch_fault: got %b expected %b", fetch_fault, BOUNDS); end
    endtask

    task automatic test_async_reset();
        step();
        expect_head("pre_rst", 32'h198, BOUNDS ? NOP : 32'hA000_0066);
        rst = 1'b1;
        #1;
        n_checks++;
        if (id_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst id_valid: got %b expected 0", id_valid); end
        n_checks++;
        if (id_instr !== NOP) begin n_fail++; $display("FAIL async_rst id_instr: got %h expected %h", id_instr, NOP); end
        n_checks++;
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL async_rst imem_addr: got %h expected 0", imem_addr); end
        n_checks++;
        if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL async_rst fetch_fault: got %b expected 0", fetch_fault); end
        #1;
        rst = 1'b0;
        step();
        expect_head("restart0", 32'h0, 32'hA000_0000);
        step();
        expect_head("restart1", 32'h4, 32'hA000_0001);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_bounds();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
